// File: rtl/bus_arbiter.sv
// Three-master round-robin bus arbiter with a hold limit under contention.
// A one-cycle GAP always separates two owners. preempt flags a forced handover.
module bus_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req,
    input  logic       m1_req,
    input  logic       m2_req,
    output logic       m0_grant,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic [1:0] owner,
    output logic       bus_busy,
    output logic       preempt,
    output logic [7:0] hold_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN  = 2'b01,
        GAP  = 2'b10
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);
    localparam logic [1:0] NO_OWNER   = 2'b11;

    // Round-robin pick: the search starts just after the previous owner.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [2:0] win;
        win = 3'b000;
        case (last)
            2'd0: begin
                if (req[1])      win = 3'b010;
                else if (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
                else             win = 3'b000;
            end
            2'd1: begin
                if (req[2])      win = 3'b100;
                else if (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
                else             win = 3'b000;
            end
            default: begin
                if (req[0])      win = 3'b001;
                else if (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
                else             win = 3'b000;
            end
        endcase
        return win;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b001:  idx = 2'd0;
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = NO_OWNER;
        endcase
        return idx;
    endfunction

    state_t      state_r, state_s;
    logic [2:0]  grant_r, grant_s;
    logic [1:0]  owner_r, owner_s;
    logic [1:0]  last_owner_r, last_owner_s;
    logic        busy_r, busy_s;
    logic        preempt_r, preempt_s;
    logic [7:0]  hold_r, hold_s;
    logic [2:0]  req_s;
    logic [2:0]  pick_s;
    logic        owner_req_s;
    logic        contend_s;
    logic [7:0]  hold_inc_s;

    // Next-state and next-output decode.
    always_comb begin
        req_s        = {m2_req, m1_req, m0_req};
        pick_s       = rr_pick(req_s, last_owner_r);
        owner_req_s  = |(req_s & grant_r);
        contend_s    = |(req_s & ~grant_r);
        hold_inc_s   = (hold_r == 8'hFF) ? 8'hFF : (hold_r + 8'd1);
        state_s      = state_r;
        grant_s      = grant_r;
        owner_s      = owner_r;
        last_owner_s = last_owner_r;
        busy_s       = busy_r;
        preempt_s    = 1'b0;
        hold_s       = hold_r;
        case (state_r)
            IDLE, GAP: begin
                if (|req_s) begin
                    state_s      = OWN;
                    grant_s      = pick_s;
                    owner_s      = onehot_idx(pick_s);
                    last_owner_s = onehot_idx(pick_s);
                    busy_s       = 1'b1;
                    hold_s       = 8'd0;
                end else begin
                    state_s = IDLE;
                    grant_s = 3'b000;
                    owner_s = NO_OWNER;
                    busy_s  = 1'b0;
                end
            end
            OWN: begin
                // Release wins over the hold limit when both happen together.
                if (!owner_req_s) begin
                    state_s = GAP;
                    grant_s = 3'b000;
                    owner_s = NO_OWNER;
                    busy_s  = 1'b0;
                end else if (contend_s && (hold_inc_s >= HOLD_LIMIT)) begin
                    state_s   = GAP;
                    grant_s   = 3'b000;
                    owner_s   = NO_OWNER;
                    busy_s    = 1'b0;
                    preempt_s = 1'b1;
                    hold_s    = hold_inc_s;
                end else if (contend_s) begin
                    hold_s = hold_inc_s;
                end else begin
                    hold_s = hold_r;
                end
            end
            default: begin
                state_s = IDLE;
                grant_s = 3'b000;
                owner_s = NO_OWNER;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            grant_r      <= 3'b000;
            owner_r      <= NO_OWNER;
            last_owner_r <= 2'd2;
            busy_r       <= 1'b0;
            preempt_r    <= 1'b0;
            hold_r       <= 8'd0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            owner_r      <= owner_s;
            last_owner_r <= last_owner_s;
            busy_r       <= busy_s;
            preempt_r    <= preempt_s;
            hold_r       <= hold_s;
        end
    end

    assign m0_grant = grant_r[0];
    assign m1_grant = grant_r[1];
    assign m2_grant = grant_r[2];
    assign owner    = owner_r;
    assign bus_busy = busy_r;
    assign preempt  = preempt_r;
    assign hold_cnt = hold_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed vectors with hand-computed
// expectations, then a random request phase checked against invariants.
module tb_bus_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int WAIT_MAX = 2 * (MAX_HOLD + 1);

    logic       clk = 1'b0;
    logic       reset;
    logic       m0_req, m1_req, m2_req;
    logic       m0_grant, m1_grant, m2_grant;
    logic [1:0] owner;
    logic       bus_busy, preempt;
    logic [7:0] hold_cnt;

    typedef struct packed {
        logic [2:0]  g;
        logic [1:0]  o;
        logic        p;
        logic [7:0]  h;
        logic [15:0] id;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         step_no = 0;
    int         cyc = 0;
    int         wait_c[3] = '{0, 0, 0};
    logic [2:0] prev_g = 3'b000;

    bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m2_req(m2_req),
        .m0_grant(m0_grant), .m1_grant(m1_grant), .m2_grant(m2_grant),
        .owner(owner), .bus_busy(bus_busy), .preempt(preempt), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0h want %0h", nm, idx, got, want);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic rst, input logic [2:0] req, input logic [2:0] g,
                        input logic [1:0] o, input logic p, input logic [7:0] h);
        exp_t e;
        reset = rst;
        {m2_req, m1_req, m0_req} = req;
        @(posedge clk);
        e.g = g; e.o = o; e.p = p; e.h = h; e.id = 16'(step_no);
        exp_q.push_back(e);
        step_no++;
        #1;
    endtask

    // Monitor: pop expectations and check invariants every cycle.
    always @(negedge clk) begin
        logic [2:0] g_now;
        exp_t e;
        g_now = {m2_grant, m1_grant, m0_grant};
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grant",   int'(e.id), {5'd0, g_now},    {5'd0, e.g});
            chk("owner",   int'(e.id), {6'd0, owner},    {6'd0, e.o});
            chk("busy",    int'(e.id), {7'd0, bus_busy}, {7'd0, (e.g != 3'b000)});
            chk("preempt", int'(e.id), {7'd0, preempt},  {7'd0, e.p});
            chk("hold",    int'(e.id), hold_cnt,         e.h);
        end
        chk("onehot", cyc, {7'd0, ($countones(g_now) <= 1)}, 8'd1);
        chk("no_gap", cyc, {7'd0, (prev_g != 3'b000 && g_now != 3'b000 && prev_g != g_now)}, 8'd0);
        chk("busy_inv", cyc, {7'd0, bus_busy}, {7'd0, (g_now != 3'b000)});
        for (int i = 0; i < 3; i++) begin
            if (g_now[i] && !prev_g[i])
                chk($sformatf("wait_m%0d", i), cyc, {7'd0, (wait_c[i] <= WAIT_MAX)}, 8'd1);
        end
        wait_c[0] = (m0_req && !g_now[0]) ? wait_c[0] + 1 : 0;
        wait_c[1] = (m1_req && !g_now[1]) ? wait_c[1] + 1 : 0;
        wait_c[2] = (m2_req && !g_now[2]) ? wait_c[2] + 1 : 0;
        prev_g = g_now;
    end

    initial begin
        logic [2:0] req_v;
        int         rem[3];
        reset = 1'b1;
        {m2_req, m1_req, m0_req} = 3'b000;

        // Reset ignores requests
        step(1'b1, 3'b111, 3'b000, 2'd3, 1'b0, 8'd0);
        step(1'b1, 3'b111, 3'b000, 2'd3, 1'b0, 8'd0);

        // Three-way contention: m0 forced off after the hold limit
        step(1'b0, 3'b111, 3'b001, 2'd0, 1'b0, 8'd0);
        for (int i = 1; i <= 6; i++) step(1'b0, 3'b111, 3'b001, 2'd0, 1'b0, 8'(i));
        step(1'b0, 3'b111, 3'b000, 2'd3, 1'b1, 8'd7);
        step(1'b0, 3'b111, 3'b010, 2'd1, 1'b0, 8'd0);
        step(1'b0, 3'b111, 3'b010, 2'd1, 1'b0, 8'd1);

        // m1 releases with m0 and m2 waiting: m2 next, then m0
        step(1'b0, 3'b101, 3'b000, 2'd3, 1'b0, 8'd1);
        step(1'b0, 3'b101, 3'b100, 2'd2, 1'b0, 8'd0);
        step(1'b0, 3'b101, 3'b100, 2'd2, 1'b0, 8'd1);
        step(1'b0, 3'b001, 3'b000, 2'd3, 1'b0, 8'd1);
        step(1'b0, 3'b001, 3'b001, 2'd0, 1'b0, 8'd0);
        step(1'b0, 3'b001, 3'b001, 2'd0, 1'b0, 8'd0);
        step(1'b0, 3'b000, 3'b000, 2'd3, 1'b0, 8'd0);
        step(1'b0, 3'b000, 3'b000, 2'd3, 1'b0, 8'd0);

        // Release coinciding with the hold limit is a normal release
        step(1'b0, 3'b011, 3'b010, 2'd1, 1'b0, 8'd0);
        for (int i = 1; i <= 6; i++) step(1'b0, 3'b011, 3'b010, 2'd1, 1'b0, 8'(i));
        step(1'b0, 3'b001, 3'b000, 2'd3, 1'b0, 8'd6);
        step(1'b0, 3'b001, 3'b001, 2'd0, 1'b0, 8'd0);
        step(1'b0, 3'b000, 3'b000, 2'd3, 1'b0, 8'd0);
        step(1'b0, 3'b000, 3'b000, 2'd3, 1'b0, 8'd0);

        // Lone requester is never preempted
        step(1'b0, 3'b100, 3'b100, 2'd2, 1'b0, 8'd0);
        for (int i = 0; i < 299; i++) step(1'b0, 3'b100, 3'b100, 2'd2, 1'b0, 8'd0);
        step(1'b0, 3'b000, 3'b000, 2'd3, 1'b0, 8'd0);
        step(1'b0, 3'b000, 3'b000, 2'd3, 1'b0, 8'd0);

        // Reset mid-ownership drops the grant at once
        step(1'b0, 3'b001, 3'b001, 2'd0, 1'b0, 8'd0);
        step(1'b0, 3'b001, 3'b001, 2'd0, 1'b0, 8'd0);
        step(1'b1, 3'b011, 3'b000, 2'd3, 1'b0, 8'd0);
        step(1'b0, 3'b010, 3'b010, 2'd1, 1'b0, 8'd0);
        step(1'b0, 3'b010, 3'b010, 2'd1, 1'b0, 8'd0);
        step(1'b0, 3'b000, 3'b000, 2'd3, 1'b0, 8'd0);

        repeat (3) @(negedge clk);
        chk("drain", cyc, 8'(exp_q.size()), 8'd0);

        // Random phase: requests held until served for a random count of grant cycles
        req_v = 3'b000;
        rem = '{0, 0, 0};
        @(posedge clk); #1;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (req_v[i]) begin
                    if ({m2_grant, m1_grant, m0_grant} & (3'b001 << i)) begin
                        rem[i]--;
                        if (rem[i] <= 0) req_v[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    req_v[i] = 1'b1;
                    rem[i] = int'($urandom_range(1, 12));
                end
            end
            {m2_req, m1_req, m0_req} = req_v;
            @(posedge clk); #1;
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("final_wait_m%0d", i), cyc, {7'd0, (wait_c[i] <= WAIT_MAX)}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
